// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_pkg
// Description : Register map, status/control bit positions and FSM encoding
//               shared by the SD-card SPI controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_spi_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_RXV   = 1;
    localparam int STAT_OVR   = 2;

    localparam int CTRL_SS_EN = 0;
    localparam int CTRL_LBK   = 2;
    localparam int CTRL_DIV_L = 8;
    localparam int CTRL_DIV_H = 15;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LOAD = 3'd1;
    localparam state_t S_LOW  = 3'd2;
    localparam state_t S_HIGH = 3'd3;
    localparam state_t S_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sd_spi_tick.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_tick
// Description : SCK half-period counter; ticks every div+1 cycles while run
//               is high. The divisor is re-sampled only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_tick (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] div_i,
    input  logic       run_i,
    output logic       tick_o
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] div_q, div_d;

    always_comb begin
        tick_o = run_i && (cnt_q == div_q);
        cnt_d  = cnt_q + 8'd1;
        div_d  = div_q;
        if (!run_i || tick_o) begin
            cnt_d = 8'd0;
            div_d = div_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
            div_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_ctrl
// Description : Memory-mapped SPI mode-0 master for SD cards, byte transfers.
//               Optional loopback bit enabled by macro SD_SPI_LOOPBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
import sd_spi_pkg::*;

module sd_spi_ctrl #(
    parameter int XLEN    = 32,
    parameter int DIV_RST = 52
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        addr_i,
    input  logic              we_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [XLEN-1:0]   data_i,
    output logic [XLEN-1:0]   data_o,
    output logic              ready_o,
    output logic              spi_sck_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_ss_o
);

    state_t          state_q, state_d;
    logic [7:0]      tx_q, tx_d, sh_q, sh_d, rxsh_q, rxsh_d, rx_byte_q, rx_byte_d;
    logic [7:0]      div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic            rx_valid_q, rx_valid_d, ovr_q, ovr_d, ss_en_q, ss_en_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            lbk_q, lbk_d;
    logic            busy, tick, run, miso, data_wr, accept, rd, wr;
    logic            unused_bits;

    assign unused_bits = ^{data_i[XLEN-1:16], be_i[XLEN/8-1:2]};

    assign wr      = en_i && we_i;
    assign rd      = en_i && !we_i;
    assign data_wr = wr && (addr_i == REG_DATA) && be_i[0];
    assign accept  = data_wr && (state_q == S_IDLE);
    assign run     = (state_q == S_LOW) || (state_q == S_HIGH);

`ifdef SD_SPI_LOOPBACK_EN
    assign miso = lbk_q ? spi_mosi_o : spi_miso_i;
`else
    assign miso = spi_miso_i;
`endif

    sd_spi_tick u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .div_i  (div_q),
        .run_i  (run),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOAD;
            S_LOAD:  state_d = S_LOW;
            S_LOW:   if (tick) state_d = S_HIGH;
            S_HIGH:  if (tick) state_d = (bit_q == 3'd7) ? S_DONE : S_LOW;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        spi_sck_o  = (state_q == S_HIGH);
        spi_mosi_o = (state_q == S_IDLE) ? 1'b1 : sh_q[7];
        spi_ss_o   = ~ss_en_q;
        ready_o    = ready_q;
        data_o     = data_q;
    end

    always_comb begin
        tx_d       = accept ? data_i[7:0] : tx_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        rxsh_d     = rxsh_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        ss_en_d    = ss_en_q;
        lbk_d      = 1'b0;
        div_d      = div_q;
        ready_d    = en_i;
        data_d     = data_q;

        if (state_q == S_LOAD) begin
            sh_d  = tx_q;
            bit_d = 3'd0;
        end
        if (state_q == S_LOW && tick)
            rxsh_d = {rxsh_q[6:0], miso};
        if (state_q == S_HIGH && tick && bit_q != 3'd7) begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
        end

        // Clears come first so that same-cycle sets take priority.
        if (rd && addr_i == REG_DATA)
            rx_valid_d = 1'b0;
        if (state_q == S_DONE) begin
            rx_byte_d  = rxsh_q;
            rx_valid_d = 1'b1;
        end
        if (wr && addr_i == REG_STATUS && be_i[0] && data_i[STAT_OVR])
            ovr_d = 1'b0;
        if (data_wr && busy)
            ovr_d = 1'b1;

`ifdef SD_SPI_LOOPBACK_EN
        lbk_d = lbk_q;
`endif
        if (wr && addr_i == REG_CTRL) begin
            if (be_i[0]) begin
                ss_en_d = data_i[CTRL_SS_EN];
`ifdef SD_SPI_LOOPBACK_EN
                lbk_d   = data_i[CTRL_LBK];
`endif
            end
            if (be_i[1])
                div_d = data_i[CTRL_DIV_H:CTRL_DIV_L];
        end

        if (en_i) begin
            data_d = '0;
            if (rd) begin
                case (addr_i)
                    REG_DATA:   data_d[7:0] = rx_byte_q;
                    REG_STATUS: begin
                        data_d[STAT_BUSY] = busy;
                        data_d[STAT_RXV]  = rx_valid_q;
                        data_d[STAT_OVR]  = ovr_q;
                    end
                    REG_CTRL:   begin
                        data_d[CTRL_DIV_H:CTRL_DIV_L] = div_q;
                        data_d[CTRL_LBK]              = lbk_q;
                        data_d[CTRL_SS_EN]            = ss_en_q;
                    end
                    default:    data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q       <= 8'd0;
            sh_q       <= 8'd0;
            bit_q      <= 3'd0;
            rxsh_q     <= 8'd0;
            rx_byte_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ss_en_q    <= 1'b0;
            lbk_q      <= 1'b0;
            div_q      <= 8'(DIV_RST);
            ready_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            tx_q       <= tx_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            rxsh_q     <= rxsh_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ss_en_q    <= ss_en_d;
            lbk_q      <= lbk_d;
            div_q      <= div_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
        end
    end

endmodule
`default_nettype wire
